// File: rtl/rr_arbiter_7way_if.sv
// Request/grant bundle between the seven requesters and rr_arbiter_7way.
// The arbiter connects to the slave modport; requesters drive through the master modport.
interface rr_arbiter_7way_if;
  logic       Enable;
  logic [6:0] Request;
  logic [6:0] Grant;
  logic       Grant_Valid;
  logic [2:0] Grant_Index;
  logic       Any_Request;

  modport master (
    output Enable, Request,
    input  Grant, Grant_Valid, Grant_Index, Any_Request
  );

  modport slave (
    input  Enable, Request,
    output Grant, Grant_Valid, Grant_Index, Any_Request
  );
endinterface

// File: rtl/rr_arbiter_7way.sv
// Seven-way round-robin arbiter with a registered one-hot grant held until the owner releases.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles while other requesters wait.
module rr_arbiter_7way #(
  parameter int unsigned UUID     = 0,
  parameter string       NAME     = "",
  parameter int unsigned MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  rr_arbiter_7way_if.slave bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state, state_n;
  logic [2:0] owner, owner_n;
  logic [2:0] ptr, ptr_n;
  logic [6:0] others;
  logic       rotate;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_cnt_n;
`endif

  function automatic logic [2:0] inc7(input logic [2:0] i);
    return (i == 3'd6) ? 3'd0 : i + 3'd1;
  endfunction

  // First set bit of req scanning start, start+1, ... with wrap 6 -> 0.
  function automatic logic [2:0] pick(input logic [6:0] req, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] sel;
    logic       found;
    idx   = start;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = inc7(idx);
    end
    return sel;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_cnt_n;
`endif
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
`endif
    others  = bus.Request & ~(7'd1 << owner);
    rotate  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Enable && (|bus.Request)) begin
          state_n = OWNED;
          owner_n = pick(bus.Request, ptr);
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end
      end
      OWNED: begin
        rotate = !bus.Request[owner];
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt == HOLD_LAST && bus.Enable && (|others)) rotate = 1'b1;
`endif
        if (rotate) begin
          // Handover on the release edge itself, searching just past the old owner.
          ptr_n = inc7(owner);
          if (bus.Enable && (|others)) begin
            owner_n = pick(others, inc7(owner));
`ifdef ARB_TIMEOUT_EN
            hold_cnt_n = '0;
`endif
          end else begin
            state_n = IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant outputs decode flops only, so they change exactly at clock edges or reset.
  always_comb begin
    bus.Grant       = '0;
    bus.Grant_Valid = 1'b0;
    bus.Grant_Index = '0;
    if (state == OWNED) begin
      bus.Grant       = 7'd1 << owner;
      bus.Grant_Valid = 1'b1;
      bus.Grant_Index = owner + 3'd1;
    end
  end

  assign bus.Any_Request = |bus.Request;

endmodule

// File: tb/tb_rr_arbiter_7way.sv
// Self-checking bench for rr_arbiter_7way: vector table, hand-written corner sequences and
// randomized traffic compared against a requester-number level model.
module tb_rr_arbiter_7way;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  rr_arbiter_7way_if bus ();

  rr_arbiter_7way #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: owner number 1..7 (0 = none), first candidate index 0..6, hold cycles.
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  typedef struct {
    logic       en;
    logic [6:0] req;
    int         exp_idx;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int pick(input logic [6:0] req, input int start);
    for (int k = 0; k < 7; k++) begin
      int i;
      i = (start + k) % 7;
      if (req[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input logic en, input logic [6:0] req);
    logic [6:0] rest;
    bit         release_now;
    if (m_owner == 0) begin
      if (en && req != 0) begin
        m_owner = pick(req, m_ptr);
        m_cnt   = 0;
      end
    end else begin
      rest        = req;
      rest[m_owner-1] = 1'b0;
      release_now = !req[m_owner-1];
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == MAX_HOLD - 1 && en && rest != 0) release_now = 1'b1;
`endif
      if (release_now) begin
        m_ptr = m_owner % 7;
        if (en && rest != 0) begin
          m_owner = pick(rest, m_ptr);
          m_cnt   = 0;
        end else begin
          m_owner = 0;
        end
      end else if (m_cnt < MAX_HOLD - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic en, input logic [6:0] req);
    bus.Enable  = en;
    bus.Request = req;
    model_edge(en, req);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    logic [6:0] exp_grant;
    exp_grant = (m_owner == 0) ? 7'd0 : (7'd1 << (m_owner - 1));
    check({name, "_index"}, 32'(bus.Grant_Index), 32'(m_owner));
    check({name, "_grant"}, 32'(bus.Grant), 32'(exp_grant));
    check({name, "_valid"}, 32'(bus.Grant_Valid), 32'(m_owner != 0));
  endtask

  task automatic do_reset();
    bus.Enable  = 1'b1;
    bus.Request = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_vec(input string name, input int exp_idx);
    logic [6:0] exp_grant;
    exp_grant = (exp_idx == 0) ? 7'd0 : (7'd1 << (exp_idx - 1));
    check({name, "_index"}, 32'(bus.Grant_Index), 32'(exp_idx));
    check({name, "_grant"}, 32'(bus.Grant), 32'(exp_grant));
    check({name, "_valid"}, 32'(bus.Grant_Valid), 32'(exp_idx != 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Round-robin from reset with each owner dropping after one cycle, then Enable gating.
    vecs[0]  = '{1'b1, 7'h7F, 1};
    vecs[1]  = '{1'b1, 7'h7E, 2};
    vecs[2]  = '{1'b1, 7'h7D, 3};
    vecs[3]  = '{1'b1, 7'h7B, 4};
    vecs[4]  = '{1'b1, 7'h77, 5};
    vecs[5]  = '{1'b1, 7'h6F, 6};
    vecs[6]  = '{1'b1, 7'h5F, 7};
    vecs[7]  = '{1'b1, 7'h3F, 1};
    vecs[8]  = '{1'b1, 7'h40, 7};
    vecs[9]  = '{1'b0, 7'h00, 0};
    vecs[10] = '{1'b0, 7'h7F, 0};
    vecs[11] = '{1'b1, 7'h7F, 1};

    bus.Enable  = 1'b1;
    bus.Request = '0;
    #1;
    check_vec("in_reset", 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    for (int c = 0; c < 10; c++) begin
      step(1'b1, 7'h00);
      check_vec("idle_after_reset", 0);
      check("idle_any_request", 32'(bus.Any_Request), 32'd0);
    end

    for (int v = 0; v < 12; v++) begin
      step(vecs[v].en, vecs[v].req);
      check_vec($sformatf("vec%0d", v), vecs[v].exp_idx);
      check($sformatf("vec%0d_any", v), 32'(bus.Any_Request), 32'(vecs[v].req != 0));
    end

`ifndef ARB_TIMEOUT_EN
    // Owner 1 holds indefinitely while requester 7 waits, then hands over on release.
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 7'h41);
      check("hold_grant", 32'(bus.Grant), 32'h01);
    end
    step(1'b1, 7'h40);
    check_vec("handover_to_7", 7);
`else
    // Forced rotation every MAX_HOLD cycles; a lone owner is never revoked.
    do_reset();
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      step(1'b1, 7'h03);
      check_vec("timeout_rotate", ((c / MAX_HOLD) % 2 == 1) ? 2 : 1);
    end
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 7'h01);
      check_vec("timeout_lone_owner", 1);
    end
`endif

    // Enable low blocks handover on release; the pending requester wins once enabled.
    do_reset();
    step(1'b1, 7'h04);
    check_vec("en_owner3", 3);
    step(1'b0, 7'h10);
    check_vec("en_blocked_release", 0);
    step(1'b1, 7'h10);
    check_vec("en_restored", 5);

    // Asynchronous reset between edges clears the grant immediately and the pointer.
    #3;
    rst = 1'b0;
    #1;
    check_vec("async_reset", 0);
    check("async_reset_any", 32'(bus.Any_Request), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 7'h44);
    check_vec("after_reset_ptr", 3);

    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [6:0] req;
      logic       en;
      req = 7'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      if (m_owner != 0 && $urandom_range(0, 3) != 0) req[m_owner-1] = 1'b1;
      step(en, req);
      check_model("rand");
      check("rand_any", 32'(bus.Any_Request), 32'(req != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
